// File: rtl/onehot_table_controller.sv
// onehot_table_controller
// Run-time programmable one-hot Moore controller. The next-state table
// NS[state][cond] and the output table OUT[state] live in registers and are
// written through the prog_* port. The present state is a one-hot vector in
// which bit NSTATES-1 stands for state 0. An all-zero vector means idle.
// Any vector with more than one bit set is illegal. The controller returns to
// idle from an illegal vector and sets a sticky error flag.
module onehot_table_controller #(
  parameter int  NSTATES = 7,
  parameter int  NCOND   = 2,
  parameter int  CPW     = 5,
  localparam int SW      = (NSTATES > 1) ? $clog2(NSTATES) : 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               en,
  input  logic [NCOND-1:0]   cond,
  input  logic               prog_we,
  input  logic               prog_oe,
  input  logic [SW-1:0]      prog_st,
  input  logic [NCOND-1:0]   prog_col,
  input  logic [SW-1:0]      prog_next,
  input  logic [CPW-1:0]     prog_cp,
  output logic [CPW-1:0]     cp,
  output logic [NSTATES-1:0] pres_state,
  output logic               err
);

  localparam int NCOL = 1 << NCOND;

  localparam logic [NSTATES-1:0] ST_IDLE = {NSTATES{1'b0}};
  localparam logic [NSTATES-1:0] ST_ONE  = {{(NSTATES-1){1'b0}}, 1'b1};
  // One-hot code of state 0 (the MSB of the vector).
  localparam logic [NSTATES-1:0] ST_S0   = {1'b1, {(NSTATES-1){1'b0}}};
  localparam logic [SW:0]        NSTATES_W = (SW+1)'(NSTATES);

  // Classification of the present-state vector.
  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_RUN     = 2'd1,
    MODE_ILLEGAL = 2'd2
  } mode_e;

  // Table storage: ns_q[s][c] is the next state index, out_q[s] the control word.
  logic [NSTATES-1:0][NCOL-1:0][SW-1:0] ns_q;
  logic [NSTATES-1:0][CPW-1:0]          out_q;

  logic [NSTATES-1:0] state_q;
  logic [NSTATES-1:0] state_d;
  logic               err_q;
  logic               err_d;

  mode_e              mode_s;
  logic               multi_s;
  logic [SW-1:0]      cur_idx_s;
  logic [SW-1:0]      lookup_s;
  logic               st_ok_s;
  logic               next_ok_s;
  logic               ns_we_s;
  logic               out_we_s;

  // State index -> one-hot vector; out-of-range indices give all-zero.
  function automatic logic [NSTATES-1:0] idx_to_onehot(input logic [SW-1:0] idx);
    logic [NSTATES-1:0] v;
    v = ST_IDLE;
    for (int i = 0; i < NSTATES; i++) begin
      if (idx == SW'(i)) begin
        v[NSTATES-1-i] = 1'b1;
      end else begin
        v[NSTATES-1-i] = 1'b0;
      end
    end
    return v;
  endfunction

  // One-hot vector -> state index; only meaningful for a one-hot input.
  function automatic logic [SW-1:0] onehot_to_idx(input logic [NSTATES-1:0] v);
    logic [SW-1:0] idx;
    idx = {SW{1'b0}};
    for (int i = 0; i < NSTATES; i++) begin
      if (v[NSTATES-1-i]) begin
        idx = idx | SW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Classify the present state: idle, legal one-hot, or multiple bits set.
  always_comb begin
    multi_s = ((state_q & (state_q - ST_ONE)) != ST_IDLE);
    if (state_q == ST_IDLE) begin
      mode_s = MODE_IDLE;
    end else if (multi_s) begin
      mode_s = MODE_ILLEGAL;
    end else begin
      mode_s = MODE_RUN;
    end
  end

  // Table lookup for the present state; the lookup sees the pre-write contents.
  always_comb begin
    cur_idx_s = onehot_to_idx(state_q);
    lookup_s  = ns_q[cur_idx_s][cond];
  end

  // Qualify programming writes; out-of-range indices drop the write.
  always_comb begin
    st_ok_s   = ({1'b0, prog_st} < NSTATES_W);
    next_ok_s = ({1'b0, prog_next} < NSTATES_W);
    ns_we_s   = prog_we && st_ok_s && next_ok_s;
    out_we_s  = prog_oe && st_ok_s;
  end

  // Table registers: cleared only by clr, written on the rising edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ns_q  <= {(NSTATES*NCOL*SW){1'b0}};
      out_q <= {(NSTATES*CPW){1'b0}};
    end else begin
      if (ns_we_s) begin
        ns_q[prog_st][prog_col] <= prog_next;
      end
      if (out_we_s) begin
        out_q[prog_st] <= prog_cp;
      end
    end
  end

  // Next-state and error: start, then illegal recovery, then hold, then table step.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (start) begin
      state_d = ST_S0;
      err_d   = 1'b0;
    end else if (mode_s == MODE_ILLEGAL) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (!en) begin
      state_d = state_q;
    end else begin
      case (mode_s)
        MODE_RUN:  state_d = idx_to_onehot(lookup_s);
        MODE_IDLE: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Present-state and sticky error registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Moore decode: control word of a legal state, zero when idle or illegal.
  always_comb begin
    if (mode_s == MODE_RUN) begin
      cp = out_q[cur_idx_s];
    end else begin
      cp = {CPW{1'b0}};
    end
  end

  assign pres_state = state_q;
  assign err        = err_q;

endmodule
